// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, the unified memory port and the register file.
// Supports lw, sw, R-type, I-type ALU, beq and jal, with memory wait states.
// The per-state control fields are registered alongside the state register.
// Only the strobes that must react to MemReady, Zero or reset are combined
// combinationally at the outputs.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int INSTRET_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ImmSrc,
  output logic                 IllegalOp,
  output logic [INSTRET_W-1:0] Instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};
  localparam logic [INSTRET_W-1:0] INSTRET_ZERO = {INSTRET_W{1'b0}};

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       pc_upd;    // unconditional PC update (jal)
    logic       fetch;     // FETCH: IR load and PC+4 gated by MemReady
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = {$bits(ctrl_t){1'b0}};

  // Moore output fields for a given state; unlisted fields stay 0.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = CTRL_NONE;
    case (s)
      S_FETCH: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_upd    = 1'b1;
      end
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

  state_t                 state_r;
  state_t                 state_next_s;
  ctrl_t                  ctrl_r;
  logic [INSTRET_W-1:0]   instret_r;
  logic                   ready_s;
  logic                   retire_s;
  logic                   illegal_s;
  logic [1:0]             imm_src_s;

  assign ready_s = MEM_HANDSHAKE ? MemReady : 1'b1;

  // Next-state selection plus retire and illegal-opcode detection.
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (ready_s) state_next_s = S_DECODE;
        else         state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = S_EXECR;
          OP_I:         state_next_s = S_EXECI;
          OP_BEQ:       state_next_s = S_BEQ;
          OP_JAL:       state_next_s = S_JAL;
          default: begin
            state_next_s = S_FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SW) state_next_s = S_MEMWRITE;
        else             state_next_s = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (ready_s) state_next_s = S_MEMWB;
        else         state_next_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (ready_s) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXECR, S_EXECI, S_JAL: state_next_s = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // State, registered control fields and retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_FETCH;
      ctrl_r    <= ctrl_of(S_FETCH);
      instret_r <= INSTRET_ZERO;
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= ctrl_of(state_next_s);
      if (retire_s) instret_r <= instret_r + INSTRET_ONE;
      else          instret_r <= instret_r;
    end
  end

  // Immediate format selection straight from the opcode.
  always_comb begin
    imm_src_s = 2'b00;
    case (op)
      OP_SW:   imm_src_s = 2'b01;
      OP_BEQ:  imm_src_s = 2'b10;
      OP_JAL:  imm_src_s = 2'b11;
      default: imm_src_s = 2'b00;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted access stops at once.
  assign PCWrite   = rst & ((ctrl_r.fetch & ready_s) | ctrl_r.pc_upd | (ctrl_r.branch & Zero));
  assign IRWrite   = rst & ctrl_r.fetch & ready_s;
  assign RegWrite  = rst & ctrl_r.reg_write;
  assign MemWrite  = rst & ctrl_r.mem_write;
  assign IllegalOp = rst & illegal_s;
  assign AdrSrc    = ctrl_r.adr_src;
  assign ResultSrc = ctrl_r.result_src;
  assign ALUSrcA   = ctrl_r.alu_src_a;
  assign ALUSrcB   = ctrl_r.alu_src_b;
  assign ALUOp     = ctrl_r.alu_op;
  assign ImmSrc    = imm_src_s;
  assign Instret   = instret_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and checks the full control vector against hand-written values.
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [31:0] Instret;

  int checks;
  int failures;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .IllegalOp(IllegalOp), .Instret(Instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,IllegalOp}
  function automatic logic [13:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] aop, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, ill};
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp, input logic [31:0] exp_ir);
    logic [13:0] obs;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, IllegalOp};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctrl: observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (Instret === exp_ir) else begin
      failures++;
      $error("FAIL %s instret: observed=%0d expected=%0d", tag, Instret, exp_ir);
    end
  endtask

  task automatic chk_imm(input string tag, input logic [1:0] exp);
    checks++;
    assert (ImmSrc === exp) else begin
      failures++;
      $error("FAIL %s immsrc: observed=%b expected=%b", tag, ImmSrc, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [13:0] RST, F1, F0, D, DILL, MA, MR, MWB, MW, XR, XI, AWB, BQ1, BQ0, JL;
    checks   = 0;
    failures = 0;
    RST  = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0);
    F1   = v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0);
    F0   = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0);
    D    = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0);
    DILL = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b1);
    MA   = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0);
    MR   = v(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0);
    MWB  = v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0);
    MW   = v(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0);
    XR   = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0);
    XI   = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0);
    AWB  = v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0);
    BQ1  = v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0);
    BQ0  = v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0);
    JL   = v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0);

    // Reset with MemReady high: strobes must stay gated
    rst = 1'b0; op = 7'b0110011; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset", RST, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1 chk("r_fetch", F1, 32'd0);

    // R-type add
    tick(); chk("r_decode", D, 32'd0); chk_imm("r_imm", 2'b00);
    tick(); chk("r_execr", XR, 32'd0);
    tick(); chk("r_aluwb", AWB, 32'd0);
    tick(); chk("r_done", F1, 32'd1);

    // lw with two MEMREAD wait cycles
    op = 7'b0000011;
    tick(); chk("lw_decode", D, 32'd1); chk_imm("lw_imm", 2'b00);
    tick(); chk("lw_memadr", MA, 32'd1);
    tick(); MemReady = 1'b0; #1 chk("lw_memread_w1", MR, 32'd1);
    tick(); chk("lw_memread_w2", MR, 32'd1);
    tick(); MemReady = 1'b1; #1 chk("lw_memread_rdy", MR, 32'd1);
    tick(); chk("lw_memwb", MWB, 32'd1);
    tick(); chk("lw_done", F1, 32'd2);

    // beq taken
    op = 7'b1100011;
    tick(); chk("beq1_decode", D, 32'd2); chk_imm("beq_imm", 2'b10);
    tick(); Zero = 1'b1; #1 chk("beq1_taken", BQ1, 32'd2);
    tick(); Zero = 1'b0; #1 chk("beq1_done", F1, 32'd3);
    // beq not taken
    tick(); chk("beq0_decode", D, 32'd3);
    tick(); chk("beq0_nottaken", BQ0, 32'd3);
    tick(); chk("beq0_done", F1, 32'd4);

    // sw with three wait cycles
    op = 7'b0100011;
    tick(); chk("sw_decode", D, 32'd4); chk_imm("sw_imm", 2'b01);
    tick(); chk("sw_memadr", MA, 32'd4);
    tick(); MemReady = 1'b0; #1 chk("sw_w1", MW, 32'd4);
    tick(); chk("sw_w2", MW, 32'd4);
    tick(); chk("sw_w3", MW, 32'd4);
    tick(); MemReady = 1'b1; #1 chk("sw_rdy", MW, 32'd4);
    tick(); chk("sw_done", F1, 32'd5);

    // Illegal opcode
    op = 7'b1110011;
    tick(); chk("ill_decode", DILL, 32'd5); chk_imm("ill_imm", 2'b00);
    tick(); chk("ill_fetch", F1, 32'd5);

    // jal: retires only through ALUWB -> FETCH
    op = 7'b1101111;
    tick(); chk("jal_decode", D, 32'd5); chk_imm("jal_imm", 2'b11);
    tick(); chk("jal_jal", JL, 32'd5);
    tick(); chk("jal_aluwb", AWB, 32'd5);
    tick(); chk("jal_done", F1, 32'd6);

    // I-type, with a fetch wait cycle first
    op = 7'b0010011; MemReady = 1'b0;
    #1 chk("i_fetch_wait", F0, 32'd6);
    tick(); chk("i_fetch_wait2", F0, 32'd6);
    MemReady = 1'b1;
    #1 chk("i_fetch_rdy", F1, 32'd6);
    tick(); chk("i_decode", D, 32'd6);
    tick(); chk("i_execi", XI, 32'd6);
    tick(); chk("i_aluwb", AWB, 32'd6);
    tick(); chk("i_done", F1, 32'd7);

    // Reset in the middle of a stalled store
    op = 7'b0100011;
    tick(); chk("swr_decode", D, 32'd7);
    tick(); chk("swr_memadr", MA, 32'd7);
    tick(); MemReady = 1'b0; #1 chk("swr_memwrite", MW, 32'd7);
    #2 rst = 1'b0;
    #1 chk("swr_reset", RST, 32'd0);
    tick(); chk("swr_reset_hold", RST, 32'd0);
    @(negedge clk); rst = 1'b1; MemReady = 1'b1;
    #1 chk("swr_fetch", F1, 32'd0);
    tick(); chk("swr_decode2", D, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
